// File: rtl/ramp_sequencer.sv
// ramp_sequencer: steers an external load/up/down counter through a programmed
// number of triangle sweeps between a captured lower and upper limit.
module ramp_sequencer #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CYC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [WIDTH-1:0] lo_lim,
  input  logic [WIDTH-1:0] hi_lim,
  input  logic [CYC_W-1:0] n_cycles,
  input  logic [WIDTH-1:0] cnt_val,
  output logic [WIDTH-1:0] cnt_in,
  output logic             cnt_load,
  output logic             cnt_up,
  output logic             cnt_down,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cyc_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RAMP_UP = 3'd2,
    S_RAMP_DN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic [CYC_W-1:0] n_q;
  logic [CYC_W-1:0] cyc_q, cyc_d, cyc_inc;
  logic             err_q, err_d;
  logic             capture;
  logic             cfg_ok;

  assign cyc_count = cyc_q;
  assign err       = err_q;

  // State register; reset parks the FSM in IDLE without touching the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured configuration, completed-cycle count and the registered err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q  <= '0;
      hi_q  <= '0;
      n_q   <= '0;
      cyc_q <= '0;
      err_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      err_q <= err_d;
      if (capture) begin
        lo_q <= lo_lim;
        hi_q <= hi_lim;
        n_q  <= n_cycles;
      end
    end
  end

  // Next state and counter controls; abort outranks pause, and both only act
  // while a sweep is in progress. Turns use equality only, so an out-of-range
  // counter value keeps being driven toward the target limit.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    err_d    = 1'b0;
    capture  = 1'b0;
    cnt_in   = '0;
    cnt_load = 1'b0;
    cnt_up   = 1'b0;
    cnt_down = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    cfg_ok   = (lo_lim < hi_lim) && (n_cycles != '0);
    cyc_inc  = cyc_q + CYC_W'(1);

    if (busy && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              capture = 1'b1;
              cyc_d   = '0;
              state_d = S_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          cnt_in = lo_q;
          if (!pause) begin
            cnt_load = 1'b1;
            state_d  = S_RAMP_UP;
          end
        end
        S_RAMP_UP: begin
          if (!pause) begin
            if (cnt_val == hi_q) begin
              state_d = S_RAMP_DN;
            end else begin
              cnt_up = 1'b1;
            end
          end
        end
        S_RAMP_DN: begin
          if (!pause) begin
            if (cnt_val == lo_q) begin
              cyc_d   = cyc_inc;
              state_d = (cyc_inc == n_q) ? S_DONE : S_RAMP_UP;
            end else begin
              cnt_down = 1'b1;
            end
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: table-driven sweeps, hand-written pause/abort/reset
// sequences, and a randomized run against a schedule-based reference model.
module tb_ramp_sequencer;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned CYC_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pause = 1'b0;
  logic [WIDTH-1:0] lo_lim = '0;
  logic [WIDTH-1:0] hi_lim = '0;
  logic [CYC_W-1:0] n_cycles = '0;
  logic [WIDTH-1:0] cnt_val;
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_load, cnt_up, cnt_down, busy, done, err;
  logic [CYC_W-1:0] cyc_count;

  logic [WIDTH-1:0] cnt_q = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int lo;
    int hi;
    int n;
    int exp_err;
    int exp_lat;
    int exp_cyc;
  } vec_t;

  always #5 clk = ~clk;

  // External 5-bit load/up/down counter; not reset by the sequencer.
  assign cnt_val = cnt_q;
  always @(posedge clk) begin
    if (cnt_load)      cnt_q <= cnt_in;
    else if (cnt_up)   cnt_q <= cnt_q + WIDTH'(1);
    else if (cnt_down) cnt_q <= cnt_q - WIDTH'(1);
  end

  ramp_sequencer #(.WIDTH(WIDTH), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .n_cycles(n_cycles), .cnt_val(cnt_val),
    .cnt_in(cnt_in), .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_down(cnt_down),
    .busy(busy), .done(done), .err(err), .cyc_count(cyc_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One start with the given config; checks err/load timing, done latency,
  // limit turns and final cycle count. Entered and left at cycle start, DUT idle.
  task automatic run_vec(input vec_t v);
    int lat;
    int viol;
    int loads;
    int errs;
    int busy_seen;
    lo_lim   = WIDTH'(v.lo);
    hi_lim   = WIDTH'(v.hi);
    n_cycles = CYC_W'(v.n);
    start    = 1'b1;
    sample();
    chk("idle_before_start", int'(busy), 0);
    next_cycle();
    start    = 1'b0;
    lo_lim   = WIDTH'($urandom_range(0, 31));
    hi_lim   = WIDTH'($urandom_range(0, 31));
    n_cycles = CYC_W'($urandom_range(0, 15));
    lat = -1; viol = 0; loads = 0; errs = 0; busy_seen = 0;
    for (int k = 1; k <= 300; k++) begin
      sample();
      if (k == 1) begin
        chk("err_timing", int'(err), v.exp_err);
        chk("load_timing", int'(cnt_load), 1 - v.exp_err);
        if (v.exp_err == 0) chk("load_data", int'(cnt_in), v.lo);
      end
      if (cnt_load) loads++;
      if (err) errs++;
      if (busy) busy_seen++;
      if (cnt_up && cnt_down) viol++;
      if (cnt_up && int'(cnt_val) == v.hi) viol++;
      if (cnt_down && int'(cnt_val) == v.lo) viol++;
      if (done) begin
        lat = k;
        break;
      end
      if (v.exp_err != 0 && k == 4) break;
      next_cycle();
    end
    chk("done_latency", lat, v.exp_lat);
    chk("limit_turns", viol, 0);
    chk("load_count", loads, 1 - v.exp_err);
    chk("err_count", errs, v.exp_err);
    if (v.exp_err != 0) chk("busy_on_reject", busy_seen, 0);
    chk("cyc_count_end", int'(cyc_count), v.exp_cyc);
    next_cycle();
  endtask

  function automatic int cyc_at(input int p, input int span);
    if (p == 0) return 0;
    return (p - 1) / (2 * span);
  endfunction

  initial begin
    vec_t tbl[9];
    vec_t v;
    int lat, flag, dones;
    // reference model: position along the sweep schedule of the active run
    int m_active, m_pos, m_len, m_lo, m_hi, m_n, m_span, m_cyc, m_err_pend;
    int e_load, e_up, e_dn, e_in, e_busy, e_done, e_err, e_cyc, e_val, r, rk;
    int r_lo, r_hi, r_n;

    // lo, hi, n, err, done latency, cyc_count afterwards
    tbl = '{
      '{2,  5,  1, 0,  10, 1},
      '{0,  31, 2, 0, 130, 2},
      '{7,  7,  1, 1,  -1, 2},
      '{3,  9,  0, 1,  -1, 2},
      '{9,  3,  2, 1,  -1, 2},
      '{1,  4,  1, 0,  10, 1},
      '{0,  1,  3, 0,  14, 3},
      '{30, 31, 1, 0,   6, 1},
      '{31, 0,  5, 1,  -1, 1}
    };

    // Reset state
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cyc", int'(cyc_count), 0);
    chk("rst_load", int'(cnt_load), 0);
    chk("rst_cnt_in", int'(cnt_in), 0);
    chk("rst_updown", int'({cnt_up, cnt_down}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Pause for five cycles while cnt_val=3 on the way up
    lo_lim = 5'd1; hi_lim = 5'd4; n_cycles = 4'd1; start = 1'b1;
    sample();
    next_cycle();
    start = 1'b0;
    lat = -1; flag = 0;
    for (int k = 1; k <= 100; k++) begin
      pause = (k >= 4 && k <= 8);
      sample();
      if (pause && (cnt_up || cnt_val != 5'd3 || !busy)) flag++;
      if (done) begin
        lat = k;
        break;
      end
      next_cycle();
    end
    pause = 1'b0;
    chk("pause_hold", flag, 0);
    chk("pause_done_latency", lat, 15);
    chk("pause_cyc", int'(cyc_count), 1);
    next_cycle();

    // Abort while counting down through 4 in the second cycle
    lo_lim = 5'd1; hi_lim = 5'd6; n_cycles = 4'd3; start = 1'b1;
    sample();
    next_cycle();
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 22; k++) begin
      abort = (k == 22);
      sample();
      if (done) dones++;
      if (k == 22) begin
        chk("abort_cnt_val", int'(cnt_val), 4);
        chk("abort_cyc_before", int'(cyc_count), 1);
        chk("abort_ctrl_zero", int'({cnt_load, cnt_up, cnt_down}), 0);
      end
      next_cycle();
    end
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      if (done || busy) dones++;
      next_cycle();
    end
    chk("abort_no_done_or_busy", dones, 0);
    chk("abort_cyc_kept", int'(cyc_count), 1);
    v = '{2, 5, 1, 0, 10, 1};
    run_vec(v);

    // Reset in the middle of RAMP_UP
    lo_lim = 5'd0; hi_lim = 5'd20; n_cycles = 4'd1; start = 1'b1;
    sample();
    next_cycle();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sample();
      next_cycle();
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ctrl", int'({cnt_load, cnt_up, cnt_down, done, err}), 0);
    chk("mid_rst_cnt_in", int'(cnt_in), 0);
    chk("mid_rst_cyc", int'(cyc_count), 0);
    next_cycle();
    chk("mid_rst_counter_kept", int'(cnt_val), 3);
    rst = 1'b0;
    run_vec(v);

    // Randomized run against the schedule model
    m_active = 0; m_pos = 0; m_len = 0; m_lo = 0; m_hi = 0; m_n = 0;
    m_span = 1; m_cyc = 1; m_err_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      r_lo = $urandom_range(0, 28);
      r_hi = r_lo + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) r_hi = $urandom_range(0, 31);
      r_n = $urandom_range(0, 3);
      lo_lim   = WIDTH'(r_lo);
      hi_lim   = WIDTH'(r_hi);
      n_cycles = CYC_W'(r_n);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 59) == 0);
      pause = ($urandom_range(0, 5) == 0);
      sample();

      e_load = 0; e_up = 0; e_dn = 0; e_in = 0; e_done = 0; e_val = -1;
      e_busy = m_active; e_err = m_err_pend; e_cyc = m_cyc;
      if (m_active != 0) begin
        e_cyc = cyc_at(m_pos, m_span);
        if (m_pos >= 1 && m_pos <= m_len - 2) begin
          rk = (m_pos - 1) % (2 * m_span);
          e_val = (rk < m_span) ? (m_lo + rk) : (m_hi - (rk - m_span));
        end
        if (abort) begin
          e_done = 0;
        end else if (m_pos == m_len - 1) begin
          e_done = 1;
        end else if (m_pos == 0) begin
          e_in = m_lo;
          e_load = pause ? 0 : 1;
        end else if (!pause) begin
          rk = (m_pos - 1) % (2 * m_span);
          if (rk < m_span) e_up = (e_val != m_hi);
          else             e_dn = (e_val != m_lo);
        end
      end
      chk("rnd_load", int'(cnt_load), e_load);
      chk("rnd_up", int'(cnt_up), e_up);
      chk("rnd_down", int'(cnt_down), e_dn);
      chk("rnd_cnt_in", int'(cnt_in), e_in);
      chk("rnd_busy", int'(busy), e_busy);
      chk("rnd_done", int'(done), e_done);
      chk("rnd_err", int'(err), e_err);
      chk("rnd_cyc", int'(cyc_count), e_cyc);
      if (e_val >= 0) chk("rnd_cnt_val", int'(cnt_val), e_val);

      m_err_pend = 0;
      if (m_active != 0) begin
        m_cyc = cyc_at(m_pos, m_span);
        if (abort || m_pos == m_len - 1) m_active = 0;
        else if (!pause) m_pos++;
      end else if (start) begin
        if (r_lo < r_hi && r_n != 0) begin
          m_active = 1; m_pos = 0; m_lo = r_lo; m_hi = r_hi; m_n = r_n;
          m_span = r_hi - r_lo + 1;
          m_len = 2 + 2 * m_n * m_span;
          m_cyc = 0;
        end else begin
          m_err_pend = 1;
        end
      end
      r = c;
      next_cycle();
    end
    start = 1'b0; abort = 1'b0; pause = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got time limit expired, required normal completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
